digest_readout_ctrl: RTL and testbench

//  Sequencer for the 8x32-bit digest output buffer. On a hash-complete pulse it strobes the

---
 rtl/digest_readout_ctrl.sv | 120 ++++++++++++
 tb/tb_digest_readout_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/digest_readout_ctrl.sv
// Readout sequencer for the 8x32 digest buffer: latches the digest on start, then streams
// buffer addresses FIRST_ADDR..FIRST_ADDR+NUM_WORDS-1 out on a valid/ready interface.
module digest_readout_ctrl #(
  parameter int unsigned NUM_WORDS  = 8,
  parameter int unsigned FIRST_ADDR = 1,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              buf_en,
  output logic [ADDR_W-1:0] buf_addr,
  input  logic [DATA_W-1:0] buf_word,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic [2:0]        m_index,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam int unsigned IDX_W = 3;
  localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_ADDR);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(FIRST_ADDR + NUM_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LATCH,
    S_FILL,
    S_STREAM
  } state_t;

  state_t              state_q;
  logic                buf_en_q;
  logic [ADDR_W-1:0]   buf_addr_q;
  logic                m_valid_q;
  logic                m_last_q;
  logic [IDX_W-1:0]    m_index_q;
  logic                busy_q;
  logic                done_q;
  logic                overrun_q;

  // Sequencer; every output except m_data comes straight from a register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      buf_en_q   <= 1'b0;
      buf_addr_q <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      m_index_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      buf_en_q <= 1'b0;
      done_q   <= 1'b0;
      if (start && (state_q != S_IDLE)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          buf_addr_q <= '0;
          if (start) begin
            state_q   <= S_LATCH;
            buf_en_q  <= 1'b1;
            busy_q    <= 1'b1;
            overrun_q <= 1'b0;
          end
        end
        // Address stays 0 (buffer no-op) while the buffer captures the digest.
        S_LATCH: begin
          buf_addr_q <= FIRST_A;
          state_q    <= S_FILL;
        end
        S_FILL: begin
          state_q   <= S_STREAM;
          m_valid_q <= 1'b1;
          m_index_q <= IDX_W'(buf_addr_q - FIRST_A);
          m_last_q  <= (buf_addr_q == LAST_A);
        end
        S_STREAM: begin
          if (m_ready) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            if (m_last_q) begin
              state_q    <= S_IDLE;
              buf_addr_q <= '0;
              m_index_q  <= '0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              state_q    <= S_FILL;
              buf_addr_q <= buf_addr_q + ADDR_W'(1);
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign buf_en   = buf_en_q;
  assign buf_addr = buf_addr_q;
  assign m_valid  = m_valid_q;
  assign m_last   = m_last_q;
  assign m_index  = m_index_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overrun  = overrun_q;

  // Buffer re-reads the held address under stall, so the gated word stays stable.
  assign m_data = m_valid_q ? buf_word : '0;

endmodule

// File: tb/tb_digest_readout_ctrl.sv
// Directed bench for digest_readout_ctrl with a behavioural model of the 8x32 digest buffer.
module tb_digest_readout_ctrl;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          m_ready = 1'b1;
  logic          buf_en;
  logic [AW-1:0] buf_addr;
  logic [DW-1:0] buf_word;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic [2:0]    m_index;
  logic          busy;
  logic          done;
  logic          overrun;

  logic [DW-1:0] din   [8];
  logic [DW-1:0] mem   [8];
  logic [DW-1:0] exp_w [8];
  logic [DW-1:0] iv    [8];

  logic [DW-1:0] got_w [8];
  logic [2:0]    got_i [8];
  logic          got_l [8];
  int nacc, done_cyc, first_cyc, stall_bad, gate_bad, stall_seen;

  int checks = 0;
  int failures = 0;

  digest_readout_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .buf_en   (buf_en),
    .buf_addr (buf_addr),
    .buf_word (buf_word),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_last   (m_last),
    .m_index  (m_index),
    .busy     (busy),
    .done     (done),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  // Buffer: captures din on buf_en, registered read of addresses 1..8, address 0 holds.
  always @(posedge clk) begin
    if (buf_en) begin
      for (int i = 0; i < 8; i++) mem[i] <= din[i];
    end
    if (buf_addr >= 4'd1 && buf_addr <= 4'd8) buf_word <= mem[int'(buf_addr) - 1];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start is sampled at the next edge; returns in the LATCH cycle (T+1).
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Drives m_ready and records accepted words until done appears; cyc0 is the current cycle offset from T.
  task automatic collect(input int cyc0, input int stall_idx, input int stall_n, input int ovr_idx);
    logic [DW-1:0] hold;
    bit injected;
    nacc = 0; done_cyc = -1; first_cyc = -1; stall_bad = 0; gate_bad = 0; stall_seen = 0;
    injected = 1'b0;
    hold = '0;
    for (int cyc = cyc0; cyc < cyc0 + 60; cyc++) begin
      start = 1'b0;
      m_ready = 1'b1;
      if (!m_valid && m_data !== '0) gate_bad++;
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      if (m_valid === 1'b1) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (ovr_idx >= 0 && !injected && int'(m_index) == ovr_idx) begin
          start = 1'b1;
          injected = 1'b1;
        end
        if (int'(m_index) == stall_idx && stall_seen < stall_n) begin
          if (stall_seen == 0) hold = m_data;
          if (m_data !== hold || buf_addr !== AW'(stall_idx + 1)) stall_bad++;
          m_ready = 1'b0;
          stall_seen++;
        end else begin
          if (nacc < 8) begin
            got_w[nacc] = m_data;
            got_i[nacc] = m_index;
            got_l[nacc] = m_last;
          end
          nacc++;
        end
      end
      tick();
    end
    start = 1'b0;
    m_ready = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++;
    if ({buf_en, buf_addr, m_valid, m_last, m_index, busy, done, overrun} !== 13'd0 || m_data !== '0) begin
      failures++;
      $display("FAIL reset_values got en=%b addr=%0d v=%b last=%b idx=%0d busy=%b done=%b ovr=%b data=%h exp all 0",
               buf_en, buf_addr, m_valid, m_last, m_index, busy, done, overrun, m_data);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    for (int i = 0; i < 8; i++) begin din[i] = iv[i]; exp_w[i] = iv[i]; end
    do_start();
    checks++;
    if (buf_en !== 1'b1 || busy !== 1'b1 || buf_addr !== 4'd0 || m_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_latch got en=%b busy=%b addr=%0d v=%b exp en=1 busy=1 addr=0 v=0", buf_en, busy, buf_addr, m_valid);
    end
    tick();
    checks++;
    if (buf_en !== 1'b0 || buf_addr !== 4'd1 || m_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_fill got en=%b addr=%0d v=%b exp en=0 addr=1 v=0", buf_en, buf_addr, m_valid);
    end
    collect(2, -1, 0, -1);
    checks++;
    if (first_cyc != 3 || nacc != 8 || done_cyc != 18 || gate_bad != 0) begin
      failures++;
      $display("FAIL basic_timing got first=%0d n=%0d done=%0d gate=%0d exp 3 8 18 0", first_cyc, nacc, done_cyc, gate_bad);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got_w[i] !== exp_w[i] || got_i[i] !== 3'(i) || got_l[i] !== (i == 7)) begin
        failures++;
        $display("FAIL basic_word%0d got %h idx=%0d last=%b exp %h idx=%0d last=%b", i, got_w[i], got_i[i], got_l[i], exp_w[i], i, i == 7);
      end
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || buf_addr !== 4'd0 || m_valid !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL basic_idle got done=%b busy=%b addr=%0d v=%b ovr=%b exp all 0", done, busy, buf_addr, m_valid, overrun);
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 8; i++) begin din[i] = iv[i]; exp_w[i] = iv[i]; end
    do_start();
    collect(1, 3, 5, -1);
    checks++;
    if (stall_seen != 5 || stall_bad != 0 || nacc != 8 || done_cyc != 23) begin
      failures++;
      $display("FAIL bp_stall got stalls=%0d bad=%0d n=%0d done=%0d exp 5 0 8 23", stall_seen, stall_bad, nacc, done_cyc);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got_w[i] !== exp_w[i] || got_i[i] !== 3'(i) || got_l[i] !== (i == 7)) begin
        failures++;
        $display("FAIL bp_word%0d got %h idx=%0d last=%b exp %h idx=%0d last=%b", i, got_w[i], got_i[i], got_l[i], exp_w[i], i, i == 7);
      end
    end
    tick();
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 8; i++) begin din[i] = iv[i]; exp_w[i] = iv[i]; end
    do_start();
    collect(1, -1, 0, 2);
    checks++;
    if (overrun !== 1'b1 || nacc != 8 || done_cyc != 18) begin
      failures++;
      $display("FAIL ovr_set got ovr=%b n=%0d done=%0d exp 1 8 18", overrun, nacc, done_cyc);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got_w[i] !== exp_w[i] || got_i[i] !== 3'(i)) begin
        failures++;
        $display("FAIL ovr_word%0d got %h idx=%0d exp %h idx=%0d", i, got_w[i], got_i[i], exp_w[i], i);
      end
    end
    repeat (2) tick();
    checks++;
    if (overrun !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ovr_sticky got ovr=%b busy=%b exp ovr=1 busy=0", overrun, busy);
    end
    do_start();
    checks++;
    if (overrun !== 1'b0 || buf_en !== 1'b1) begin
      failures++;
      $display("FAIL ovr_clear got ovr=%b en=%b exp ovr=0 en=1", overrun, buf_en);
    end
    collect(1, -1, 0, -1);
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) din[i] = iv[i];
    do_start();
    collect(1, -1, 0, -1);
    for (int i = 0; i < 8; i++) begin din[i] = 32'h1111_1111; exp_w[i] = 32'h1111_1111; end
    do_start();
    checks++;
    if (buf_en !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL b2b_latch got en=%b busy=%b done=%b ovr=%b exp 1 1 0 0", buf_en, busy, done, overrun);
    end
    collect(1, -1, 0, -1);
    checks++;
    if (nacc != 8 || done_cyc != 18) begin
      failures++;
      $display("FAIL b2b_timing got n=%0d done=%0d exp 8 18", nacc, done_cyc);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got_w[i] !== exp_w[i] || got_i[i] !== 3'(i) || got_l[i] !== (i == 7)) begin
        failures++;
        $display("FAIL b2b_word%0d got %h idx=%0d last=%b exp %h idx=%0d last=%b", i, got_w[i], got_i[i], got_l[i], exp_w[i], i, i == 7);
      end
    end
    tick();
  endtask

  task automatic test_latch_timing();
    for (int i = 0; i < 8; i++) begin din[i] = iv[7 - i]; exp_w[i] = iv[7 - i]; end
    do_start();
    tick();
    for (int i = 0; i < 8; i++) din[i] = 32'hDEAD_0000 + DW'(i);
    collect(2, -1, 0, -1);
    checks++;
    if (nacc != 8 || done_cyc != 18) begin
      failures++;
      $display("FAIL latch_timing got n=%0d done=%0d exp 8 18", nacc, done_cyc);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got_w[i] !== exp_w[i]) begin
        failures++;
        $display("FAIL latch_word%0d got %h exp %h", i, got_w[i], exp_w[i]);
      end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bit found;
    for (int i = 0; i < 8; i++) din[i] = iv[i];
    do_start();
    found = 1'b0;
    for (int c = 0; c < 30; c++) begin
      start = (m_valid === 1'b1 && m_index == 3'd1) ? 1'b1 : 1'b0;
      if (m_valid === 1'b1 && m_index == 3'd2) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    start = 1'b0;
    checks++;
    if (!found || overrun !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_reach got found=%b ovr=%b exp found=1 ovr=1", found, overrun);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({buf_en, buf_addr, m_valid, m_last, m_index, busy, done, overrun} !== 13'd0 || m_data !== '0) begin
      failures++;
      $display("FAIL rstmid_async got en=%b addr=%0d v=%b last=%b idx=%0d busy=%b done=%b ovr=%b data=%h exp all 0",
               buf_en, buf_addr, m_valid, m_last, m_index, busy, done, overrun, m_data);
    end
    tick();
    rst = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (done !== 1'b0 || busy !== 1'b0 || m_valid !== 1'b0) found = 1'b1;
      tick();
    end
    checks++;
    if (found) begin
      failures++;
      $display("FAIL rstmid_abandon got activity after reset exp idle with no done");
    end
  endtask

  initial begin
    iv = '{32'h6A09E667, 32'hBB67AE85, 32'h3C6EF372, 32'hA54FF53A,
           32'h510E527F, 32'h9B05688C, 32'h1F83D9AB, 32'h5BE0CD19};
    for (int i = 0; i < 8; i++) din[i] = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_overrun();
    test_back_to_back();
    test_latch_timing();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
